// File: rtl/reindeer_decode_stage_hs.sv
// RV32 decode stage with valid/ready handshakes, a 1-entry skid buffer, flush and illegal detection.
// Optional macro REINDEER_DECODE_RV32M_EN enables decoding of the M extension (OP with IR[25]=1).
module reindeer_decode_stage_hs #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned PC_BITWIDTH   = 32,
  parameter int unsigned REG_ADDR_BITS = 5,
  parameter int unsigned CSR_BITS      = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          IR_in,
  input  logic [PC_BITWIDTH-1:0]   PC_in,
  output logic [REG_ADDR_BITS-1:0] rs1,
  output logic [REG_ADDR_BITS-1:0] rs2,
  output logic [CSR_BITS-1:0]      csr,
  output logic                     csr_read_enable,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          IR_out,
  output logic [PC_BITWIDTH-1:0]   PC_out,
  output logic [19:0]              ctl_vec,
  output logic                     illegal
);

  typedef enum logic [4:0] {
    OPC_LOAD     = 5'b00000,
    OPC_MISC_MEM = 5'b00011,
    OPC_OP_IMM   = 5'b00100,
    OPC_AUIPC    = 5'b00101,
    OPC_STORE    = 5'b01000,
    OPC_OP       = 5'b01100,
    OPC_LUI      = 5'b01101,
    OPC_BRANCH   = 5'b11000,
    OPC_JALR     = 5'b11001,
    OPC_JAL      = 5'b11011,
    OPC_SYSTEM   = 5'b11100
  } opcode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // First field is the MSB, so ctl_vec bit 0 is load_x_rs1.
  typedef struct packed {
    logic wfi;
    logic mret;
    logic misc_mem;
    logic csr_write;
    logic csr;
    logic system;
    logic store;
    logic load;
    logic branch;
    logic jalr;
    logic jal;
    logic auipc;
    logic lui;
    logic mul_div_funct3;
    logic alu_funct3;
    logic save_rd;
    logic load_y_store_off12;
    logic load_y_imm12;
    logic load_y_rs2;
    logic load_x_rs1;
  } ctl_t;

  typedef struct packed {
    logic [XLEN-1:0]        ir;
    logic [PC_BITWIDTH-1:0] pc;
    ctl_t                   ctl;
    logic                   illegal;
    logic                   csr_rd;
  } bundle_t;

  state_t  r_state;
  state_t  w_state_nxt;
  logic    r_in_ready;
  bundle_t r_out;
  bundle_t r_skid;
  bundle_t w_dec;

  logic    w_accept;
  logic    w_xfer;
  logic    w_ld_out_dec;
  logic    w_ld_out_skid;
  logic    w_ld_skid;

  ctl_t    w_ctl;
  logic    w_csr_rd;
  logic    w_known;
  logic    w_use_rd;
  logic    w_use_rs1;
  logic    w_use_rs2;
  logic    w_f3_bad;
  logic    w_mul_bad;
  logic    w_e_bad;
  logic    w_len_bad;
  logic    w_illegal;
  logic [2:0] w_f3;

  assign rs1 = IR_in[15 +: REG_ADDR_BITS];
  assign rs2 = IR_in[20 +: REG_ADDR_BITS];
  assign csr = IR_in[20 +: CSR_BITS];

  assign w_f3 = IR_in[14:12];

  always_comb begin
    w_ctl     = '0;
    w_csr_rd  = 1'b0;
    w_known   = 1'b1;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_f3_bad  = 1'b0;
    w_mul_bad = 1'b0;
    case (opcode_t'(IR_in[6:2]))
      OPC_OP_IMM: begin
        w_ctl.load_x_rs1   = 1'b1;
        w_ctl.load_y_imm12 = 1'b1;
        w_ctl.save_rd      = 1'b1;
        w_ctl.alu_funct3   = 1'b1;
        w_use_rd           = 1'b1;
        w_use_rs1          = 1'b1;
      end
      OPC_OP: begin
        w_ctl.load_x_rs1 = 1'b1;
        w_ctl.load_y_rs2 = 1'b1;
        w_ctl.save_rd    = 1'b1;
        w_use_rd         = 1'b1;
        w_use_rs1        = 1'b1;
        w_use_rs2        = 1'b1;
        if (IR_in[25]) begin
`ifdef REINDEER_DECODE_RV32M_EN
          w_ctl.mul_div_funct3 = 1'b1;
`else
          w_mul_bad = 1'b1;
`endif
        end else begin
          w_ctl.alu_funct3 = 1'b1;
        end
      end
      OPC_LUI: begin
        w_ctl.lui     = 1'b1;
        w_ctl.save_rd = 1'b1;
        w_use_rd      = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctl.auipc   = 1'b1;
        w_ctl.save_rd = 1'b1;
        w_use_rd      = 1'b1;
      end
      OPC_JAL: begin
        w_ctl.jal     = 1'b1;
        w_ctl.save_rd = 1'b1;
        w_use_rd      = 1'b1;
      end
      OPC_JALR: begin
        w_ctl.jalr         = 1'b1;
        w_ctl.load_x_rs1   = 1'b1;
        w_ctl.load_y_imm12 = 1'b1;
        w_ctl.save_rd      = 1'b1;
        w_use_rd           = 1'b1;
        w_use_rs1          = 1'b1;
      end
      OPC_BRANCH: begin
        w_ctl.branch     = 1'b1;
        w_ctl.load_x_rs1 = 1'b1;
        w_ctl.load_y_rs2 = 1'b1;
        w_use_rs1        = 1'b1;
        w_use_rs2        = 1'b1;
      end
      OPC_LOAD: begin
        // Write-back for loads comes from the memory unit, not from this bundle.
        w_ctl.load         = 1'b1;
        w_ctl.load_x_rs1   = 1'b1;
        w_ctl.load_y_imm12 = 1'b1;
        w_use_rd           = 1'b1;
        w_use_rs1          = 1'b1;
      end
      OPC_STORE: begin
        w_ctl.store              = 1'b1;
        w_ctl.load_x_rs1         = 1'b1;
        w_ctl.load_y_rs2         = 1'b1;
        w_ctl.load_y_store_off12 = 1'b1;
        w_use_rs1                = 1'b1;
        w_use_rs2                = 1'b1;
      end
      OPC_MISC_MEM: begin
        w_ctl.misc_mem = 1'b1;
      end
      OPC_SYSTEM: begin
        w_ctl.system     = 1'b1;
        w_ctl.load_x_rs1 = 1'b1;
        w_ctl.mret       = (w_f3 == 3'b000) && (IR_in[24:20] == 5'b00010);
        w_ctl.wfi        = (w_f3 == 3'b000) && (IR_in[24:20] == 5'b00101);
        w_ctl.csr        = |w_f3;
        w_ctl.save_rd    = |w_f3;
        w_ctl.csr_write  = |IR_in[19:15];
        w_csr_rd         = |w_f3;
        w_use_rd         = |w_f3;
        // Immediate CSR forms carry a zimm in the rs1 field, not a register index.
        w_use_rs1        = (|w_f3) & ~w_f3[2];
        w_f3_bad         = (w_f3 == 3'b100);
      end
      default: w_known = 1'b0;
    endcase

    w_len_bad = (IR_in[1:0] != 2'b11);
    w_e_bad   = (REG_ADDR_BITS < 5) &&
                ((w_use_rd & IR_in[11]) | (w_use_rs1 & IR_in[19]) | (w_use_rs2 & IR_in[24]));
    w_illegal = w_len_bad | ~w_known | w_mul_bad | w_f3_bad | w_e_bad;

    if (w_len_bad | ~w_known | w_mul_bad) begin
      w_ctl    = '0;
      w_csr_rd = 1'b0;
    end
  end

  always_comb begin
    w_dec         = '0;
    w_dec.ir      = IR_in;
    w_dec.pc      = PC_in;
    w_dec.ctl     = w_ctl;
    w_dec.illegal = w_illegal;
    w_dec.csr_rd  = w_csr_rd;
  end

  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = r_in_ready;
  assign w_accept  = in_valid & r_in_ready;
  assign w_xfer    = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ld_out_dec  = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    if (flush | sync_reset) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = ST_ONE;
            w_ld_out_dec = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_xfer) begin
            w_ld_out_dec = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_xfer) begin
            w_state_nxt   = ST_ONE;
            w_ld_out_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_out_dec) begin
        r_out <= w_dec;
      end else if (w_ld_out_skid) begin
        r_out <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign IR_out          = r_out.ir;
  assign PC_out          = r_out.pc;
  assign ctl_vec         = r_out.ctl;
  assign csr_read_enable = r_out.csr_rd;
  assign illegal         = r_out.illegal & out_valid;

endmodule

// File: tb/tb_reindeer_decode_stage_hs.sv
// Directed bench for reindeer_decode_stage_hs: an RV32I instance and an RV32E instance share all inputs.
module tb_reindeer_decode_stage_hs;

  logic        clk;
  logic        reset_n;
  logic        sync_reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] IR_in;
  logic [31:0] PC_in;
  logic        out_ready;

  logic        in_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] csr;
  logic        csr_read_enable;
  logic        out_valid;
  logic [31:0] IR_out;
  logic [31:0] PC_out;
  logic [19:0] ctl_vec;
  logic        illegal;

  logic        e_in_ready;
  logic [3:0]  e_rs1;
  logic [3:0]  e_rs2;
  logic [11:0] e_csr;
  logic        e_csr_read_enable;
  logic        e_out_valid;
  logic [31:0] e_IR_out;
  logic [31:0] e_PC_out;
  logic [19:0] e_ctl_vec;
  logic        e_illegal;

  int unsigned n_total;
  int unsigned n_bad;

  logic [19:0] exp_mul_ctl;
  logic [31:0] exp_mul_ill;

  reindeer_decode_stage_hs #(
    .XLEN(32), .PC_BITWIDTH(32), .REG_ADDR_BITS(5), .CSR_BITS(12)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .IR_in(IR_in), .PC_in(PC_in),
    .rs1(rs1), .rs2(rs2), .csr(csr), .csr_read_enable(csr_read_enable),
    .out_valid(out_valid), .out_ready(out_ready), .IR_out(IR_out), .PC_out(PC_out),
    .ctl_vec(ctl_vec), .illegal(illegal)
  );

  reindeer_decode_stage_hs #(
    .XLEN(32), .PC_BITWIDTH(32), .REG_ADDR_BITS(4), .CSR_BITS(12)
  ) u_dut_e (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(e_in_ready), .IR_in(IR_in), .PC_in(PC_in),
    .rs1(e_rs1), .rs2(e_rs2), .csr(e_csr), .csr_read_enable(e_csr_read_enable),
    .out_valid(e_out_valid), .out_ready(out_ready), .IR_out(e_IR_out), .PC_out(e_PC_out),
    .ctl_vec(e_ctl_vec), .illegal(e_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc);
    in_valid = v;
    IR_in    = ir;
    PC_in    = pc;
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    sync_reset = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

`ifdef REINDEER_DECODE_RV32M_EN
    exp_mul_ctl = 20'h00053;
    exp_mul_ill = 32'd0;
`else
    exp_mul_ctl = 20'h00000;
    exp_mul_ill = 32'd1;
`endif

    // Reset state
    tick();
    tick();
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_IR_out", IR_out, 32'd0);
    check_eq("rst_PC_out", PC_out, 32'd0);
    check_eq("rst_ctl_vec", {12'd0, ctl_vec}, 32'd0);
    check_eq("rst_illegal", {31'd0, illegal}, 32'd0);
    check_eq("rst_csr_re", {31'd0, csr_read_enable}, 32'd0);
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADDI x1,x0,5
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h00000100);
    #1;
    check_eq("addi_csr_comb", {20'd0, csr}, 32'h005);
    tick();
    check_eq("addi_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("addi_IR_out", IR_out, 32'h00500093);
    check_eq("addi_PC_out", PC_out, 32'h00000100);
    check_eq("addi_ctl", {12'd0, ctl_vec}, 32'h00035);
    check_eq("addi_illegal", {31'd0, illegal}, 32'd0);
    check_eq("addi_e_illegal", {31'd0, e_illegal}, 32'd0);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_eq("addi_drained", {31'd0, out_valid}, 32'd0);

    // Back-pressure: A, B, C with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 32'h00100113, 32'h00000200);
    tick();
    check_eq("bp_A_valid", {31'd0, out_valid}, 32'd1);
    check_eq("bp_A_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h00200193, 32'h00000204);
    tick();
    check_eq("bp_B_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("bp_B_IR_hold", IR_out, 32'h00100113);
    drive(1'b1, 32'h00300213, 32'h00000208);
    tick();
    check_eq("bp_C_IR_hold", IR_out, 32'h00100113);
    check_eq("bp_C_PC_hold", PC_out, 32'h00000200);
    check_eq("bp_C_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    check_eq("bp_deliver_B_IR", IR_out, 32'h00200193);
    check_eq("bp_deliver_B_PC", PC_out, 32'h00000204);
    check_eq("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    check_eq("bp_deliver_C_IR", IR_out, 32'h00300213);
    check_eq("bp_deliver_C_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_eq("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h00100113, 32'h00000300);
    tick();
    drive(1'b1, 32'h00200193, 32'h00000304);
    tick();
    check_eq("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h00500293, 32'h00000308);
    flush = 1'b1;
    tick();
    check_eq("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("fl_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("fl_illegal", {31'd0, illegal}, 32'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_eq("fl_skid_gone", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 32'h00500293, 32'h0000030c);
    flush = 1'b1;
    tick();
    check_eq("fl_accept_dropped", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_eq("fl_accept_never", {31'd0, out_valid}, 32'd0);

    // sync_reset clears a held instruction
    drive(1'b1, 32'h00100113, 32'h00000400);
    tick();
    check_eq("sr_loaded", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    out_ready  = 1'b0;
    sync_reset = 1'b1;
    tick();
    check_eq("sr_out_valid", {31'd0, out_valid}, 32'd0);
    sync_reset = 1'b0;
    out_ready  = 1'b1;

    // CSRRW x0,mstatus,x5
    drive(1'b1, 32'h30029073, 32'h00000500);
    #1;
    check_eq("csrrw_csr_comb", {20'd0, csr}, 32'h300);
    check_eq("csrrw_rs1_comb", {27'd0, rs1}, 32'd5);
    tick();
    check_eq("csrrw_ctl", {12'd0, ctl_vec}, 32'h1C011);
    check_eq("csrrw_csr_re", {31'd0, csr_read_enable}, 32'd1);
    check_eq("csrrw_illegal", {31'd0, illegal}, 32'd0);

    // MRET
    drive(1'b1, 32'h30200073, 32'h00000504);
    tick();
    check_eq("mret_ctl", {12'd0, ctl_vec}, 32'h44001);
    check_eq("mret_csr_re", {31'd0, csr_read_enable}, 32'd0);

    // Unknown opcode
    drive(1'b1, 32'h0000000B, 32'h00000508);
    tick();
    check_eq("unk_illegal", {31'd0, illegal}, 32'd1);
    check_eq("unk_ctl", {12'd0, ctl_vec}, 32'd0);

    // ADD x17,x1,x2: legal on RV32I, illegal on RV32E
    drive(1'b1, 32'h002088B3, 32'h0000050c);
    #1;
    check_eq("add17_rs2_comb", {27'd0, rs2}, 32'd2);
    check_eq("add17_e_rs1_comb", {28'd0, e_rs1}, 32'd1);
    tick();
    check_eq("add17_illegal", {31'd0, illegal}, 32'd0);
    check_eq("add17_ctl", {12'd0, ctl_vec}, 32'h00033);
    check_eq("add17_e_illegal", {31'd0, e_illegal}, 32'd1);

    // MUL x3,x1,x2
    drive(1'b1, 32'h022081B3, 32'h00000510);
    tick();
    check_eq("mul_ctl", {12'd0, ctl_vec}, {12'd0, exp_mul_ctl});
    check_eq("mul_illegal", {31'd0, illegal}, exp_mul_ill);

    // Compressed-looking encoding (low bits != 11)
    drive(1'b1, 32'h00500090, 32'h00000514);
    tick();
    check_eq("len_illegal", {31'd0, illegal}, 32'd1);

    // SYSTEM funct3=100
    drive(1'b1, 32'h3002C073, 32'h00000518);
    tick();
    check_eq("sys100_illegal", {31'd0, illegal}, 32'd1);

    // Illegal is qualified by out_valid
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_eq("end_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("end_illegal_qual", {31'd0, illegal}, 32'd0);
    check_eq("end_IR_hold", IR_out, 32'h3002C073);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
